// File: rtl/decod_scan_if.sv
// Select handshake bundle for decod_scan.
//   A        : select index (N bits), driven by the master
//   in_valid : A is valid, driven by the master
//   in_ready : decoder can accept, driven by the slave (decoder)
interface decod_scan_if #(
  parameter int unsigned N = 2
);
  logic [N-1:0] A;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output A,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  A,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/decod_scan.sv
// decod_scan: registered N-to-2**N one-hot decoder with DIRECT and SCAN modes.
//   DIRECT: a select accepted over the bus handshake is decoded into Y one cycle later.
//   SCAN  : an internal counter walks the channels, holding each for DWELL enabled cycles,
//           pulsing wrap when the walk returns to the start.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   E          : enable; low forces Y to zero and freezes the scan
//   mode       : 0 = DIRECT, 1 = SCAN
//   bus        : A / in_valid / in_ready select handshake (slave side)
//   mask       : per-channel enable, present only when DECOD_MASK_EN is defined
//   Y          : registered one-hot (or all-zero) output
//   idx        : index of the current / last decoded channel
//   wrap       : one-cycle pulse on the cycle the scan first shows its wrapped channel
// Build option: define DECOD_MASK_EN to add the mask port; otherwise all channels enabled.
module decod_scan #(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              E,
  input  logic              mode,
  decod_scan_if.slave       bus,
`ifdef DECOD_MASK_EN
  input  logic [2**N-1:0]   mask,
`endif
  output logic [2**N-1:0]   Y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned NCh = 2**N;
  localparam int unsigned DW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);

  logic [NCh-1:0] mask_w;
`ifdef DECOD_MASK_EN
  assign mask_w = mask;
`else
  assign mask_w = '1;
`endif

  logic [NCh-1:0] y_q, y_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           wrap_q, wrap_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic           mode_q;

  logic           accept;
  logic [N-1:0]   cand;
  logic [N-1:0]   next_idx;
  logic           next_found;
  logic [N-1:0]   low_idx;
  logic           any_en;

  function automatic logic [NCh-1:0] onehot(input logic [N-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign bus.in_ready = ~mode;
  assign accept       = bus.in_valid & bus.in_ready & E;

  // Next enabled channel after idx_q, searching forward modulo NCh. Iterating k downwards
  // lets the nearest candidate win; k = NCh wraps back onto idx_q itself.
  always_comb begin
    cand       = idx_q;
    next_idx   = idx_q;
    next_found = 1'b0;
    for (int k = NCh; k >= 1; k--) begin
      cand = idx_q + k[N-1:0];
      if (mask_w[cand]) begin
        next_idx   = cand;
        next_found = 1'b1;
      end
    end
  end

  // Lowest enabled channel, used as the scan starting point.
  always_comb begin
    low_idx = '0;
    for (int i = NCh - 1; i >= 0; i--) begin
      if (mask_w[i]) begin
        low_idx = i[N-1:0];
      end
    end
  end

  assign any_en = |mask_w;

  always_comb begin
    y_d     = y_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    dwell_d = dwell_q;
    if (!mode) begin
      if (!E) begin
        y_d = '0;
      end else if (accept) begin
        idx_d = bus.A;
        y_d   = onehot(bus.A) & mask_w;
      end else if (mode_q) begin
        // Leaving SCAN with no new select: blank the output, keep idx.
        y_d = '0;
      end
    end else if (!mode_q) begin
      dwell_d = '0;
      if (any_en) begin
        idx_d = low_idx;
      end
      y_d = E ? (onehot(idx_d) & mask_w) : '0;
    end else if (E) begin
      if (dwell_q == DwellLast) begin
        dwell_d = '0;
        if (next_found) begin
          idx_d  = next_idx;
          wrap_d = (next_idx <= idx_q);
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
      y_d = onehot(idx_d) & mask_w;
    end else begin
      y_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      dwell_q <= dwell_d;
      mode_q  <= mode;
    end
  end

  assign Y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
